fmul32_op_issuer: RTL and testbench
===================================

# fmul32_op_issuer

Command-side counterpart of the FMUL32 operation decode: accepts one-hot operation requests (MUL / INV_S / ABS_W) with two 32-bit operands from a client, buffers them, and encodes each into the FMUL32 operation code. Each command is presented to the FMUL32 datapath over a valid/ready handshake. When nothing is being issued, the block drives the IDLE code so the downstream decoder sees IDLE.

## Interface
- `OPERATION_NUM`, default 4: number of operation codes; code width is $clog2(OPERATION_NUM); must be 4.
- `DEPTH`, default 4: command FIFO depth; power of two, ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard all buffered, not-yet-issued commands.
- `req_valid`  in  1  client request present.
- `req_ready`  out  1  block can accept a request.
- `req_mul`, `req_inv_s`, `req_abs_w`  in  1 each  requested operation; exactly one must be set.
- `req_a`, `req_b`  in  32 each  operands.
- `op_valid`  out  1  command presented to FMUL32.
- `op_ready`  in  1  FMUL32 accepts the command.
- `operation`  out  $clog2(OPERATION_NUM)  encoded operation code.
- `op_a`, `op_b`  out  32 each  operands of the presented command.
- `err_onehot`  out  1  one-cycle pulse: an accepted request was not one-hot and was dropped.
- `fifo_count`  out  $clog2(DEPTH)+1  number of buffered commands, excluding the output register.

## Operation
- Encoding: MUL→0, INV_S→1, ABS_W→2, IDLE→3.
- Accept: a request is accepted on a cycle with `req_valid && req_ready`.
- Ready: `req_ready = !rst && fifo_count < DEPTH`. It is never raised on the strength of a same-cycle pop, so a full FIFO accepts nothing.
- Invalid requests: an accepted request with zero flags or more than one flag set is consumed but not written. `err_onehot` pulses the next cycle and `fifo_count` is unchanged.
- Encoding point: valid requests are encoded to the 2-bit code on write; the FIFO stores {code, a, b}.
- Output register state machine:
  - S_IDLE: `op_valid` = 0, `operation` = 3, operands hold their last values. If the FIFO is non-empty, load the head, pop, and go to S_ISSUE.
  - S_ISSUE: `op_valid` = 1 and the output is stable until `op_ready`. On `op_ready`: if the FIFO is non-empty, load the next head and pop, staying in S_ISSUE; otherwise go to S_IDLE.
- Flush:
  - FIFO pointers and count are cleared at the next edge.
  - A request accepted in the same cycle is dropped; `err_onehot` is not asserted for it.
  - An op already in S_ISSUE is not withdrawn. It completes its handshake, and the block then goes to S_IDLE.
  - During a flush cycle no pop occurs.
- Simultaneous push and pop on a non-full FIFO: `fifo_count` is unchanged and both actions take effect.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: `op_valid` = 0, `operation` = 3, `op_a` = `op_b` = 0, `err_onehot` = 0, `fifo_count` = 0, state S_IDLE, `req_ready` = 0 while `rst` is high.
- Reset mid-operation: a pending op is abandoned and all buffered commands are lost.
- Latency: a request accepted in cycle t is in the FIFO in t+1 and appears with `op_valid` = 1 in t+2, provided the output register is free.
- Throughput: one command per cycle with `op_ready` held high and a continuous request stream.
- `err_onehot` is high for exactly one cycle, at t+1.
- Outputs `op_valid`, `operation`, `op_a`, `op_b`, `err_onehot` are registered. `req_ready` is combinational from `fifo_count` and `rst`.

## Structure
- Package `fmul32_op_pkg`: `OP_MUL`, `OP_INV_S`, `OP_ABS_W`, `OP_IDLE` code constants, the code-width constant, and the state enum {S_IDLE, S_ISSUE}. The FMUL32 decode side shares these constants.
- Sub-module `op_cmd_fifo`: synchronous FIFO, DEPTH × (2+64) bits, with push, pop, flush, count, and full/empty outputs.
- The top level holds the one-hot check, the encoder, the output register and the state machine.

## Test plan
- Reset, then idle: `op_valid` = 0, `operation` = 3, `req_ready` = 1, `fifo_count` = 0 after `rst` falls.
- Single INV_S request with a = 0x3F800000, b = 0x40000000 and `op_ready` = 1: `op_valid` rises 2 cycles later with `operation` = 1 and operands intact. It drops the cycle after the handshake and `operation` returns to 3.
- Hold `op_ready` = 0 and push 5 MUL requests (DEPTH=4): 1 in the output register and 4 buffered, `req_ready` = 0, 6th request stalled. Releasing `op_ready` issues all 5 in order, one per cycle, all with code 0.
- Requests with flags 3'b000 and 3'b011: each pulses `err_onehot` once, `fifo_count` stays 0, and `op_valid` is never asserted.
- Flush with 3 buffered and 1 in S_ISSUE (`op_ready` low), plus a same-cycle ABS_W request: the issuing op completes after `op_ready`, nothing else is issued, and `fifo_count` = 0.
- Reset asserted while in S_ISSUE with 2 buffered: the next cycle shows `op_valid` = 0, `operation` = 3, `fifo_count` = 0.

Source files
------------

// File: rtl/fmul32_op_pkg.sv
// Shared FMUL32 operation codes, command entry layout and issuer state enum.
package fmul32_op_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_MUL   = 2'd0;
  localparam logic [OP_W-1:0] OP_INV_S = 2'd1;
  localparam logic [OP_W-1:0] OP_ABS_W = 2'd2;
  localparam logic [OP_W-1:0] OP_IDLE  = 2'd3;

  // One buffered command: encoded op plus both operands.
  typedef struct packed {
    logic [OP_W-1:0] code;
    logic [31:0]     a;
    logic [31:0]     b;
  } cmd_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  // Flags are {abs_w, inv_s, mul}; non-one-hot patterns map to IDLE and
  // are filtered out before this is ever stored.
  function automatic logic [OP_W-1:0] enc_op(input logic [2:0] flags);
    case (flags)
      3'b001:  enc_op = OP_MUL;
      3'b010:  enc_op = OP_INV_S;
      3'b100:  enc_op = OP_ABS_W;
      default: enc_op = OP_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/op_cmd_fifo.sv
// Synchronous command FIFO with flush; head is visible combinationally on dout.
module op_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 66
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_count == (AW+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;
  assign dout  = r_mem[r_rd_ptr];
  assign count = r_count;

  // Storage array; no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fmul32_op_issuer.sv
// Accepts one-hot op requests, buffers encoded commands and issues them to
// the FMUL32 datapath through a registered valid/ready output stage.
module fmul32_op_issuer
  import fmul32_op_pkg::*;
#(
  parameter int OPERATION_NUM = 4,
  parameter int DEPTH         = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_mul,
  input  logic                             req_inv_s,
  input  logic                             req_abs_w,
  input  logic [31:0]                      req_a,
  input  logic [31:0]                      req_b,
  output logic                             op_valid,
  input  logic                             op_ready,
  output logic [$clog2(OPERATION_NUM)-1:0] operation,
  output logic [31:0]                      op_a,
  output logic [31:0]                      op_b,
  output logic                             err_onehot,
  output logic [$clog2(DEPTH):0]           fifo_count
);
  localparam int OPW = $clog2(OPERATION_NUM);

  logic [2:0]     w_flags;
  logic           w_onehot;
  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic           w_load;
  logic           w_full;
  logic           w_empty;
  cmd_t           w_cmd_in;
  cmd_t           w_head;
  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_op_valid;
  logic [OPW-1:0] r_operation;
  logic [31:0]    r_op_a;
  logic [31:0]    r_op_b;
  logic           r_err;

  assign w_flags  = {req_abs_w, req_inv_s, req_mul};
  assign w_onehot = (w_flags == 3'b001) || (w_flags == 3'b010) || (w_flags == 3'b100);
  // Readiness never depends on a same-cycle pop.
  assign req_ready = !rst && !w_full;
  assign w_accept  = req_valid && req_ready;
  // Requests accepted during a flush are swallowed silently.
  assign w_push    = w_accept && w_onehot && !flush;

  assign w_cmd_in.code = enc_op(w_flags);
  assign w_cmd_in.a    = req_a;
  assign w_cmd_in.b    = req_b;

  op_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (w_push),
    .din   (w_cmd_in),
    .pop   (w_pop),
    .dout  (w_head),
    .count (fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  // Next-state: load the head whenever the output stage is free or draining.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && !flush) begin
          w_load      = 1'b1;
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          if (!w_empty && !flush) begin
            w_load = 1'b1;
            w_pop  = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op_valid  <= 1'b0;
      r_operation <= OPW'(OP_IDLE);
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_accept && !w_onehot && !flush;
      if (w_load) begin
        r_op_valid  <= 1'b1;
        r_operation <= OPW'(w_head.code);
        r_op_a      <= w_head.a;
        r_op_b      <= w_head.b;
      end else if (r_state == S_ISSUE && op_ready) begin
        // Operands hold their last values while idle.
        r_op_valid  <= 1'b0;
        r_operation <= OPW'(OP_IDLE);
      end
    end
  end

  assign op_valid   = r_op_valid;
  assign operation  = r_operation;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign err_onehot = r_err;

endmodule

// File: tb/tb_fmul32_op_issuer.sv
// Directed bench for fmul32_op_issuer with hand-computed expectations.
module tb_fmul32_op_issuer;
  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready;
  logic        req_mul, req_inv_s, req_abs_w;
  logic [31:0] req_a, req_b;
  logic        op_valid, op_ready;
  logic [1:0]  operation;
  logic [31:0] op_a, op_b;
  logic        err_onehot;
  logic [2:0]  fifo_count;

  int checks   = 0;
  int failures = 0;

  fmul32_op_issuer #(.OPERATION_NUM(4), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mul    (req_mul),
    .req_inv_s  (req_inv_s),
    .req_abs_w  (req_abs_w),
    .req_a      (req_a),
    .req_b      (req_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .operation  (operation),
    .op_a       (op_a),
    .op_b       (op_b),
    .err_onehot (err_onehot),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic v, input logic [2:0] fl, input logic [31:0] a, input logic [31:0] b);
    req_valid = v;
    {req_abs_w, req_inv_s, req_mul} = fl;
    req_a = a;
    req_b = b;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; op_ready = 1'b0;
    set_req(1'b0, 3'b000, 32'h0, 32'h0);
    cyc(); cyc();
    // Reset state
    chk("rst_req_ready", 64'(req_ready), 64'(1'b0));
    chk("rst_op_valid", 64'(op_valid), 64'(1'b0));
    chk("rst_operation", 64'(operation), 64'(2'd3));
    chk("rst_op_a", 64'(op_a), 64'(32'h0));
    chk("rst_count", 64'(fifo_count), 64'(3'd0));
    rst = 1'b0;
    #1;
    chk("idle_req_ready", 64'(req_ready), 64'(1'b1));
    cyc();
    chk("idle_op_valid", 64'(op_valid), 64'(1'b0));
    chk("idle_operation", 64'(operation), 64'(2'd3));

    // Single INV_S with op_ready high
    op_ready = 1'b1;
    set_req(1'b1, 3'b010, 32'h3F800000, 32'h40000000);
    cyc();
    set_req(1'b0, 3'b000, 32'h0, 32'h0);
    chk("inv_t1_count", 64'(fifo_count), 64'(3'd1));
    chk("inv_t1_valid", 64'(op_valid), 64'(1'b0));
    cyc();
    chk("inv_t2_valid", 64'(op_valid), 64'(1'b1));
    chk("inv_t2_op", 64'(operation), 64'(2'd1));
    chk("inv_t2_a", 64'(op_a), 64'(32'h3F800000));
    chk("inv_t2_b", 64'(op_b), 64'(32'h40000000));
    chk("inv_t2_count", 64'(fifo_count), 64'(3'd0));
    cyc();
    chk("inv_t3_valid", 64'(op_valid), 64'(1'b0));
    chk("inv_t3_op", 64'(operation), 64'(2'd3));
    chk("inv_t3_hold_a", 64'(op_a), 64'(32'h3F800000));

    // Backpressure: 5 MUL with op_ready low fills output reg + FIFO
    op_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      set_req(1'b1, 3'b001, 32'(i), 32'(100 + i));
      cyc();
    end
    set_req(1'b1, 3'b001, 32'd6, 32'd106);
    chk("full_count", 64'(fifo_count), 64'(3'd4));
    chk("full_req_ready", 64'(req_ready), 64'(1'b0));
    cyc();
    chk("stall_count", 64'(fifo_count), 64'(3'd4));
    chk("stall_a", 64'(op_a), 64'(32'd1));
    set_req(1'b0, 3'b000, 32'h0, 32'h0);
    op_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("drain%0d_valid", i), 64'(op_valid), 64'(1'b1));
      chk($sformatf("drain%0d_op", i), 64'(operation), 64'(2'd0));
      chk($sformatf("drain%0d_a", i), 64'(op_a), 64'(i));
      chk($sformatf("drain%0d_b", i), 64'(op_b), 64'(100 + i));
      cyc();
    end
    chk("drain_end_valid", 64'(op_valid), 64'(1'b0));
    chk("drain_end_op", 64'(operation), 64'(2'd3));
    chk("drain_end_count", 64'(fifo_count), 64'(3'd0));

    // Non-one-hot requests
    set_req(1'b1, 3'b000, 32'h11, 32'h22);
    cyc();
    set_req(1'b0, 3'b000, 32'h0, 32'h0);
    chk("bad000_err", 64'(err_onehot), 64'(1'b1));
    chk("bad000_count", 64'(fifo_count), 64'(3'd0));
    cyc();
    chk("bad000_err_drop", 64'(err_onehot), 64'(1'b0));
    set_req(1'b1, 3'b011, 32'h33, 32'h44);
    cyc();
    set_req(1'b0, 3'b000, 32'h0, 32'h0);
    chk("bad011_err", 64'(err_onehot), 64'(1'b1));
    chk("bad011_count", 64'(fifo_count), 64'(3'd0));
    cyc();
    chk("bad011_err_drop", 64'(err_onehot), 64'(1'b0));
    chk("bad_valid", 64'(op_valid), 64'(1'b0));

    // Flush with 1 issuing + 3 buffered and a same-cycle ABS_W
    op_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b1, 3'b010, 32'(16 + i), 32'(32 + i));
      cyc();
    end
    chk("preflush_count", 64'(fifo_count), 64'(3'd3));
    chk("preflush_a", 64'(op_a), 64'(32'd17));
    set_req(1'b1, 3'b100, 32'hAA, 32'hBB);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    set_req(1'b0, 3'b000, 32'h0, 32'h0);
    chk("flush_count", 64'(fifo_count), 64'(3'd0));
    chk("flush_err", 64'(err_onehot), 64'(1'b0));
    chk("flush_keep_valid", 64'(op_valid), 64'(1'b1));
    chk("flush_keep_a", 64'(op_a), 64'(32'd17));
    chk("flush_keep_op", 64'(operation), 64'(2'd1));
    op_ready = 1'b1;
    cyc();
    chk("flush_done_valid", 64'(op_valid), 64'(1'b0));
    chk("flush_done_op", 64'(operation), 64'(2'd3));
    cyc(); cyc();
    chk("flush_quiet_valid", 64'(op_valid), 64'(1'b0));
    chk("flush_quiet_count", 64'(fifo_count), 64'(3'd0));

    // Reset while issuing with 2 buffered
    op_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      set_req(1'b1, 3'b001, 32'(48 + i), 32'(64 + i));
      cyc();
    end
    set_req(1'b0, 3'b000, 32'h0, 32'h0);
    chk("prerst_valid", 64'(op_valid), 64'(1'b1));
    chk("prerst_count", 64'(fifo_count), 64'(3'd2));
    rst = 1'b1;
    cyc();
    chk("midrst_valid", 64'(op_valid), 64'(1'b0));
    chk("midrst_op", 64'(operation), 64'(2'd3));
    chk("midrst_count", 64'(fifo_count), 64'(3'd0));
    chk("midrst_a", 64'(op_a), 64'(32'h0));
    rst = 1'b0;
    cyc(); cyc();
    chk("postrst_valid", 64'(op_valid), 64'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
